// File: rtl/harris_response_pipe_if.sv
// Gradient-pair stream into the Harris stage and the response/corner stream out of it.
interface harris_response_pipe_if #(
    parameter int GW    = 10,
    parameter int OUT_W = 16
);
    logic                    in_valid;
    logic                    sof;
    logic signed [GW-1:0]    gx;
    logic signed [GW-1:0]    gy;
    logic signed [OUT_W-1:0] thresh;
    logic                    out_valid;
    logic signed [OUT_W-1:0] resp;
    logic                    corner;

    modport master (output in_valid, sof, gx, gy, thresh, input out_valid, resp, corner);
    modport slave  (input in_valid, sof, gx, gy, thresh, output out_valid, resp, corner);
endinterface

// File: rtl/harris_response_pipe.sv
// Streaming Harris cornerness: structure-tensor products, 1-2-1 binomial smoothing via
// line buffers, R = det - k*tr^2, saturated response and thresholded corner flag.
module harris_response_pipe #(
    parameter int GW      = 10,
    parameter int LINE_W  = 640,
    parameter int K_NUM   = 5,
    parameter int K_SHIFT = 7,
    parameter int OUT_W   = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    harris_response_pipe_if.slave s
);
    localparam int PW    = 2 * GW;
    localparam int VW    = PW + 2;
    localparam int SW    = PW + 4;
    localparam int HW    = PW + 1;
    localparam int DW    = 2 * HW + 1;
    localparam int TW    = HW + 1;
    localparam int KW    = $clog2(K_NUM + 1) + 1;
    localparam int RW    = 2 * TW + KW + 2;
    localparam int CW    = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int ROW_W = 16;
    localparam logic signed [RW-1:0] SAT_MAX = (RW'(1) <<< (OUT_W - 1)) - RW'(1);
    localparam logic signed [RW-1:0] SAT_MIN = -SAT_MAX - RW'(1);

    function automatic logic signed [OUT_W-1:0] sat(input logic signed [RW-1:0] x);
        if (x > SAT_MAX) return OUT_W'(SAT_MAX);
        if (x < SAT_MIN) return OUT_W'(SAT_MIN);
        return OUT_W'(x);
    endfunction

    logic [CW-1:0]    col;
    logic [ROW_W-1:0] row;
    logic [CW-1:0]    pix_col;
    logic [ROW_W-1:0] pix_row;
    logic             interior;

    // A qualified sof relocates the current beat to (0,0) before anything else sees it.
    always_comb begin
        pix_col  = s.sof ? '0 : col;
        pix_row  = s.sof ? '0 : row;
        interior = (pix_row >= ROW_W'(2)) && (pix_col >= CW'(2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (s.in_valid) begin
            if (pix_col == CW'(LINE_W - 1)) begin
                col <= '0;
                row <= pix_row + ROW_W'(1);
            end else begin
                col <= pix_col + CW'(1);
                row <= pix_row;
            end
        end
    end

    logic vld_p1, vld_p2, vld_p3, vld_p4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            vld_p3      <= 1'b0;
            vld_p4      <= 1'b0;
            s.out_valid <= 1'b0;
        end else begin
            vld_p1      <= s.in_valid;
            vld_p2      <= vld_p1;
            vld_p3      <= vld_p2;
            vld_p4      <= vld_p3;
            s.out_valid <= vld_p4;
        end
    end

    logic signed [GW-1:0] op_a [3];
    logic signed [GW-1:0] op_b [3];

    always_comb begin
        op_a[0] = s.gx;  op_b[0] = s.gx;
        op_a[1] = s.gy;  op_b[1] = s.gy;
        op_a[2] = s.gx;  op_b[2] = s.gy;
    end

    // Stage 1: position bookkeeping alongside the products
    logic [CW-1:0] col_p1;
    logic          int_p1, int_p2, int_p3, int_p4;

    always_ff @(posedge clk) begin
        if (s.in_valid) begin
            col_p1 <= pix_col;
            int_p1 <= interior;
        end
        if (vld_p1) int_p2 <= int_p1;
        if (vld_p2) int_p3 <= int_p2;
        if (vld_p3) int_p4 <= int_p3;
    end

    // Channels: 0 = Ixx (A), 1 = Iyy (B), 2 = Ixy (C)
    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        logic signed [PW-1:0] prod_p1;
        logic signed [PW-1:0] lb0 [LINE_W];
        logic signed [PW-1:0] lb1 [LINE_W];
        logic signed [PW-1:0] up2, up1;
        logic signed [VW-1:0] v_p2;
        logic signed [VW-1:0] vd1, vd2;
        logic signed [SW-1:0] hsum;
        logic signed [HW-1:0] h_p3;

        always_ff @(posedge clk) begin
            if (s.in_valid) prod_p1 <= PW'(op_a[ch]) * PW'(op_b[ch]);
        end

        // Stage 2: vertical 1-2-1 over rows r-2, r-1, r; buffers shift down one row
        assign up2 = lb0[col_p1];
        assign up1 = lb1[col_p1];

        always_ff @(posedge clk) begin
            if (vld_p1) begin
                v_p2        <= VW'(up2) + (VW'(up1) <<< 1) + VW'(prod_p1);
                lb0[col_p1] <= up1;
                lb1[col_p1] <= prod_p1;
            end
        end

        // Stage 3: horizontal 1-2-1 over columns c-2, c-1, c, normalised by 16
        assign hsum = SW'(vd2) + (SW'(vd1) <<< 1) + SW'(v_p2);

        always_ff @(posedge clk) begin
            if (vld_p2) begin
                vd2  <= vd1;
                vd1  <= v_p2;
                h_p3 <= HW'(hsum >>> 4);
            end
        end
    end

    logic signed [HW-1:0] a_p3, b_p3, c_p3;
    assign a_p3 = g_ch[0].h_p3;
    assign b_p3 = g_ch[1].h_p3;
    assign c_p3 = g_ch[2].h_p3;

    // Stage 4: determinant and trace, wide enough that neither can overflow
    logic signed [DW-1:0] det_p4;
    logic signed [TW-1:0] tr_p4;

    always_ff @(posedge clk) begin
        if (vld_p3) begin
            det_p4 <= DW'(a_p3) * DW'(b_p3) - DW'(c_p3) * DW'(c_p3);
            tr_p4  <= TW'(a_p3) + TW'(b_p3);
        end
    end

    // Stage 5: response, threshold compared on the unsaturated value
    logic signed [RW-1:0] r_val;
    assign r_val = RW'(det_p4) - ((RW'(K_NUM) * RW'(tr_p4) * RW'(tr_p4)) >>> K_SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s.resp   <= '0;
            s.corner <= 1'b0;
        end else if (vld_p4) begin
            s.resp   <= int_p4 ? sat(r_val) : '0;
            s.corner <= int_p4 && (r_val > RW'(s.thresh));
        end
    end
endmodule

// File: tb/tb_harris_response_pipe.sv
// Bench for harris_response_pipe: table frames with hand-derived responses plus random
// frames scored against a direct 3x3 binomial-window Harris model.
module tb_harris_response_pipe;
    localparam int GW      = 10;
    localparam int LINE_W  = 8;
    localparam int K_NUM   = 5;
    localparam int K_SHIFT = 7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    harris_response_pipe_if #(.GW(GW), .OUT_W(16)) bus16 ();
    harris_response_pipe_if #(.GW(GW), .OUT_W(12)) bus12 ();

    assign bus12.in_valid = bus16.in_valid;
    assign bus12.sof      = bus16.sof;
    assign bus12.gx       = bus16.gx;
    assign bus12.gy       = bus16.gy;

    harris_response_pipe #(.GW(GW), .LINE_W(LINE_W), .K_NUM(K_NUM), .K_SHIFT(K_SHIFT), .OUT_W(16))
        dut16 (.clk(clk), .rst_n(rst_n), .s(bus16));
    harris_response_pipe #(.GW(GW), .LINE_W(LINE_W), .K_NUM(K_NUM), .K_SHIFT(K_SHIFT), .OUT_W(12))
        dut12 (.clk(clk), .rst_n(rst_n), .s(bus12));

    typedef struct {
        int     gx; int gy_even; int gy_odd;
        int     th16; int th12; int gap;
        longint r16; bit c16; longint r12; bit c12;
    } vec_t;

    typedef struct {
        int     due; bit tab;
        longint r16; bit c16; longint r12; bit c12;
    } exp_t;

    vec_t tab [5];
    exp_t q [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   fgx [64][LINE_W];
    int   fgy [64][LINE_W];
    int   m_row = 0, m_col = 0;
    int   th16 = 0, th12 = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint satv(longint x, int w);
        longint mx;
        mx = (longint'(1) <<< (w - 1)) - 1;
        if (x > mx) return mx;
        if (x < -mx - 1) return -mx - 1;
        return x;
    endfunction

    // Harris response of the 3x3 window whose bottom-right pixel is (r,c).
    function automatic longint harris_r(int r, int c);
        longint sxx, syy, sxy, a, b, cc, det, tr, wt, px, py;
        int rr;
        sxx = 0; syy = 0; sxy = 0;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                wt  = longint'((dy == 1) ? 2 : 1) * longint'((dx == 1) ? 2 : 1);
                rr  = (r - 2 + dy) % 64;
                px  = fgx[rr][c-2+dx];
                py  = fgy[rr][c-2+dx];
                sxx += wt * px * px;
                syy += wt * py * py;
                sxy += wt * px * py;
            end
        end
        a = sxx >>> 4; b = syy >>> 4; cc = sxy >>> 4;
        det = a * b - cc * cc;
        tr  = a + b;
        return det - ((K_NUM * tr * tr) >>> K_SHIFT);
    endfunction

    // Present one beat for a cycle; src >= 0 takes interior expectations from tab[src].
    task automatic drive(input bit v, input bit sf, input int gxv, input int gyv, input int src);
        exp_t   e;
        longint r;
        bus16.in_valid = v;
        bus16.sof      = sf;
        bus16.gx       = GW'(gxv);
        bus16.gy       = GW'(gyv);
        if (v) begin
            if (sf) begin m_row = 0; m_col = 0; end
            fgx[m_row % 64][m_col] = gxv;
            fgy[m_row % 64][m_col] = gyv;
            e.due = cyc + 5;
            e.tab = (src >= 0);
            e.r16 = 0; e.c16 = 0; e.r12 = 0; e.c12 = 0;
            if (m_row >= 2 && m_col >= 2) begin
                if (src >= 0) begin
                    e.r16 = tab[src].r16; e.c16 = tab[src].c16;
                    e.r12 = tab[src].r12; e.c12 = tab[src].c12;
                end else begin
                    r     = harris_r(m_row, m_col);
                    e.r16 = satv(r, 16); e.c16 = (r > th16);
                    e.r12 = satv(r, 12); e.c12 = (r > th12);
                end
            end
            q.push_back(e);
            if (m_col == LINE_W - 1) begin m_col = 0; m_row++; end
            else m_col++;
        end
        @(negedge clk);
    endtask

    task automatic set_thresh(input int t16, input int t12);
        repeat (6) drive(1'b0, 1'b0, 0, 0, -1);
        th16 = t16; th12 = t12;
        bus16.thresh = 16'(t16);
        bus12.thresh = 12'(t12);
    endtask

    function automatic int rnd(int amp);
        return int'($urandom_range(2 * amp)) - amp;
    endfunction

    task automatic rand_frame(input int rows, input int max_gap, input bit first_sof,
                              input int sof_at, input int amp);
        for (int p = 0; p < rows * LINE_W; p++) begin
            drive(1'b1, (first_sof && p == 0) || p == sof_at, rnd(amp), rnd(amp), -1);
            repeat ($urandom_range(max_gap)) drive(1'b0, ($urandom_range(3) == 0), 0, 0, -1);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus16.out_valid) begin
                    if (q.size() == 0) begin
                        chk("spurious_out_valid", longint'(bus16.out_valid), 0);
                    end else begin
                        e = q.pop_front();
                        chk("latency", cyc, e.due);
                        chk(e.tab ? "tab_resp16" : "mdl_resp16", longint'(bus16.resp), e.r16);
                        chk(e.tab ? "tab_corner16" : "mdl_corner16", longint'(bus16.corner), e.c16);
                        chk("out_valid12", longint'(bus12.out_valid), 1);
                        chk(e.tab ? "tab_resp12" : "mdl_resp12", longint'(bus12.resp), e.r12);
                        chk(e.tab ? "tab_corner12" : "mdl_corner12", longint'(bus12.corner), e.c12);
                    end
                end else if (q.size() != 0 && q[0].due <= cyc) begin
                    chk("missing_out_valid", longint'(bus16.out_valid), 1);
                    e = q.pop_front();
                end
            end
        end
    end

    initial begin
        bus16.in_valid = 1'b0; bus16.sof = 1'b0; bus16.gx = '0; bus16.gy = '0;
        bus16.thresh = '0; bus12.thresh = '0;
        //             gx  gyE  gyO   th16    th12  gap  r16     c16  r12    c12
        tab[0] = '{    0,   0,   0,      0,      0,  0,      0, 1'b0,     0, 1'b0};
        tab[1] = '{   16,   0,   0,      0,      0,  0,  -2560, 1'b0, -2048, 1'b0};
        tab[2] = '{   16,  16, -16,   1000,   1000,  0,  32767, 1'b1,  2047, 1'b1};
        tab[3] = '{   16,  16,  16, -20000,  -2048,  0, -10240, 1'b1, -2048, 1'b0};
        tab[4] = '{    0,   0,   0,      0,      0,  2,      0, 1'b0,     0, 1'b0};

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", longint'(bus16.out_valid), 0);
        chk("rst_resp", longint'(bus16.resp), 0);
        chk("rst_corner", longint'(bus16.corner), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 5; t++) begin
            set_thresh(tab[t].th16, tab[t].th12);
            for (int p = 0; p < 5 * LINE_W; p++) begin
                drive(1'b1, p == 0, tab[t].gx,
                      ((p % LINE_W) % 2 == 0) ? tab[t].gy_even : tab[t].gy_odd, t);
                repeat (tab[t].gap) drive(1'b0, 1'b0, 0, 0, -1);
            end
        end

        // Frame restarted at row 4, col 5
        set_thresh(0, 0);
        rand_frame(8, 0, 1'b1, 4 * LINE_W + 5, 32);

        // Asynchronous reset in the middle of a busy stream
        set_thresh(500, 300);
        rand_frame(3, 0, 1'b1, -1, 64);
        bus16.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", longint'(bus16.out_valid), 0);
        chk("async_rst_resp", longint'(bus16.resp), 0);
        chk("async_rst_corner", longint'(bus16.corner), 0);
        chk("async_rst_resp12", longint'(bus12.resp), 0);
        q.delete();
        m_row = 0; m_col = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rand_frame(5, 2, 1'b0, -1, 32);

        for (int f = 0; f < 4; f++) begin
            set_thresh(rnd(3000), rnd(1500));
            rand_frame(4 + f, f % 3, 1'b1, (f == 2) ? 2 * LINE_W + 3 : -1, (f % 2 == 0) ? 24 : 511);
        end

        repeat (10) drive(1'b0, 1'b0, 0, 0, -1);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
